// File: rtl/cmn_stream_pkg.sv
// cmn_stream_pkg
// Shared constants for the stream fabric. The FIFO, the Wishbone adapter
// and the crossbar all take their default message width and queue depth
// from here, so they agree without repeating magic numbers.
package cmn_stream_pkg;

  // Default message width in bits.
  localparam int c_stream_nbits = 32;

  // Default queue depth in entries (power of two, at least 2).
  localparam int c_stream_depth = 4;

endpackage : cmn_stream_pkg

// File: rtl/cmn_RegFile_1r1w.sv
// cmn_RegFile_1r1w
// Register file with one read port and one write port. Reads are
// combinational, so the FIFO head is visible in the same cycle its read
// address changes. Writes are synchronous. Contents are not reset.
//
// Ports:
//   clk    in   write clock
//   raddr  in   read address
//   rdata  out  entry at raddr (combinational)
//   wen    in   write enable
//   waddr  in   write address
//   wdata  in   write data
module cmn_RegFile_1r1w
  import cmn_stream_pkg::*;
#(
  parameter int p_nbits    = c_stream_nbits,
  parameter int p_nentries = c_stream_depth
) (
  input  logic                            clk,
  input  logic [$clog2(p_nentries)-1:0]   raddr,
  output logic [p_nbits-1:0]              rdata,
  input  logic                            wen,
  input  logic [$clog2(p_nentries)-1:0]   waddr,
  input  logic [p_nbits-1:0]              wdata
);

  logic [p_nbits-1:0] mem [p_nentries];

  always_ff @(posedge clk) begin
    if (wen) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : cmn_RegFile_1r1w

// File: rtl/stream_fifo.sv
// stream_fifo
// Valid/ready message FIFO between the Wishbone adapter and the crossbar.
// Storage lives in cmn_RegFile_1r1w; pointer and occupancy control is here.
//
// Build option:
//   STREAM_FIFO_BYPASS_EN  when defined, an empty FIFO forwards recv_msg
//                          to send_msg combinationally; if downstream takes
//                          it in the same cycle, nothing is written.
//                          When undefined, the minimum latency is one cycle
//                          and no combinational input-to-output path exists.
//
// Ports:
//   clk       in   clock, all state updates on posedge
//   reset     in   asynchronous active-high reset
//   recv_val  in   upstream message valid
//   recv_rdy  out  FIFO can accept a message this cycle
//   recv_msg  in   upstream message
//   send_val  out  head-of-queue message is valid
//   send_rdy  in   downstream accepts the message this cycle
//   send_msg  out  head-of-queue message
//   count     out  current occupancy
module stream_fifo
  import cmn_stream_pkg::*;
#(
  parameter int p_nbits = c_stream_nbits,
  parameter int p_depth = c_stream_depth
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          recv_val,
  output logic                          recv_rdy,
  input  logic [p_nbits-1:0]            recv_msg,
  output logic                          send_val,
  input  logic                          send_rdy,
  output logic [p_nbits-1:0]            send_msg,
  output logic [$clog2(p_depth+1)-1:0]  count
);

  localparam int c_aw = $clog2(p_depth);
  localparam int c_cw = $clog2(p_depth + 1);
  localparam logic [c_cw-1:0] c_full = c_cw'(p_depth);

  logic [c_aw-1:0]    wr_ptr_q, wr_ptr_d;
  logic [c_aw-1:0]    rd_ptr_q, rd_ptr_d;
  logic [c_cw-1:0]    count_q,  count_d;
  logic [p_nbits-1:0] head_msg;
  logic               bypass;
  logic               enq;
  logic               deq;

  // Full FIFO refuses data even if a dequeue happens in the same cycle;
  // this keeps recv_rdy independent of send_rdy.
  assign recv_rdy = (count_q != c_full) && !reset;

`ifdef STREAM_FIFO_BYPASS_EN
  // Empty queue: present the incoming message directly. Gated by reset so
  // send_val is forced low while reset is held.
  assign bypass   = (count_q == '0) && recv_val && !reset;
  assign send_val = (count_q != '0) || bypass;
  assign send_msg = bypass ? recv_msg : head_msg;
`else
  assign bypass   = 1'b0;
  assign send_val = (count_q != '0);
  assign send_msg = head_msg;
`endif

  // A bypassed message taken downstream in the same cycle never touches
  // storage; a bypassed message not taken is enqueued normally.
  assign enq = recv_val && recv_rdy && !(bypass && send_rdy);
  assign deq = send_val && send_rdy && !bypass;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Depth is a power of two, so pointer wrap is natural overflow.
    if (enq) begin
      wr_ptr_d = wr_ptr_q + c_aw'(1);
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + c_aw'(1);
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + c_cw'(1);
      2'b01:   count_d = count_q - c_cw'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;

  cmn_RegFile_1r1w #(
    .p_nbits    (p_nbits),
    .p_nentries (p_depth)
  ) u_regfile (
    .clk   (clk),
    .raddr (rd_ptr_q),
    .rdata (head_msg),
    .wen   (enq),
    .waddr (wr_ptr_q),
    .wdata (recv_msg)
  );

endmodule : stream_fifo

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo
// Self-checking bench for stream_fifo (default 32-bit, depth 4). A queue
// holds the messages the FIFO should contain; every cycle the DUT outputs
// are compared with what the queue implies, then the queue is updated from
// the handshake rules. Directed scenarios are followed by random traffic.
module tb_stream_fifo;

  localparam int P_NBITS = 32;
  localparam int P_DEPTH = 4;
  localparam int P_CW    = $clog2(P_DEPTH + 1);

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                recv_val = 1'b0;
  logic                recv_rdy;
  logic [P_NBITS-1:0]  recv_msg = '0;
  logic                send_val;
  logic                send_rdy = 1'b0;
  logic [P_NBITS-1:0]  send_msg;
  logic [P_CW-1:0]     count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_q[$];

  stream_fifo #(
    .p_nbits (P_NBITS),
    .p_depth (P_DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .recv_val (recv_val),
    .recv_rdy (recv_rdy),
    .recv_msg (recv_msg),
    .send_val (send_val),
    .send_rdy (send_rdy),
    .send_msg (send_msg),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model at the
  // falling edge, then advance the model at the rising edge.
  task automatic cycle(input logic rv, input logic [31:0] msg, input logic sr);
    bit byp;
    bit exp_val;
    bit do_enq;
    bit do_deq;
    int sz;
    recv_val = rv;
    recv_msg = msg;
    send_rdy = sr;
    @(negedge clk);
    sz  = model_q.size();
    byp = 1'b0;
`ifdef STREAM_FIFO_BYPASS_EN
    byp = (sz == 0) && rv;
`endif
    exp_val = (sz != 0) || byp;
    check("recv_rdy", 32'(recv_rdy), 32'(sz != P_DEPTH));
    check("send_val", 32'(send_val), 32'(exp_val));
    if (exp_val) begin
      check("send_msg", send_msg, byp ? msg : model_q[0]);
    end
    check("count", 32'(count), 32'(sz));
    do_enq = rv && (sz != P_DEPTH) && !(byp && sr);
    do_deq = exp_val && sr && !byp;
    $display("cyc t=%0t rv=%0b msg=0x%08h sr=%0b -> send_val=%0b send_msg=0x%08h count=%0d",
             $time, rv, msg, sr, send_val, send_msg, count);
    @(posedge clk);
    if (do_deq) void'(model_q.pop_front());
    if (do_enq) model_q.push_back(msg);
    #1;
  endtask

  task automatic drain_all();
    for (int i = 0; i < 2 * P_DEPTH && model_q.size() != 0; i++) begin
      cycle(1'b0, 32'h0, 1'b1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    // Reset: asserted asynchronously, outputs forced low immediately.
    #1 reset = 1'b1;
    #1;
    check("rst_recv_rdy", 32'(recv_rdy), 32'd0);
    check("rst_send_val", 32'(send_val), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_q.delete();

    // First edge after release: ready, nothing valid.
    cycle(1'b0, 32'h0, 1'b0);

    // Single push, visible the next cycle.
    cycle(1'b1, 32'hA5A5_0001, 1'b0);
    check("push1_val", 32'(send_val), 32'd1);
    check("push1_msg", send_msg, 32'hA5A5_0001);
    check("push1_count", 32'(count), 32'd1);
    drain_all();

    // Fill to four, fifth push refused, drain in order.
    for (int i = 1; i <= 4; i++) cycle(1'b1, 32'(i), 1'b0);
    check("full_count", 32'(count), 32'd4);
    check("full_recv_rdy", 32'(recv_rdy), 32'd0);
    cycle(1'b1, 32'h5, 1'b0);
    check("full_reject_count", 32'(count), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      check("drain_order", send_msg, 32'(i));
      cycle(1'b0, 32'h0, 1'b1);
    end
    check("drained_count", 32'(count), 32'd0);

    // Steady state at two entries with simultaneous push/pop.
    cycle(1'b1, 32'h0A, 1'b0);
    cycle(1'b1, 32'h0B, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 32'h10 + 32'(i), 1'b1);
      check("steady_count", 32'(count), 32'd2);
    end
    check("steady_head", send_msg, 32'h18);
    drain_all();

    // Full with push and pop together: only the pop happens.
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h21 + 32'(i), 1'b0);
    cycle(1'b1, 32'h99, 1'b1);
    check("fullpp_count", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("fullpp_order", send_msg, 32'h22 + 32'(i));
      cycle(1'b0, 32'h0, 1'b1);
    end
    check("fullpp_empty", 32'(send_val), 32'd0);

    // Asynchronous reset mid-stream with three entries.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h31 + 32'(i), 1'b0);
    recv_val = 1'b0;
    send_rdy = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_send_val", 32'(send_val), 32'd0);
    check("async_recv_rdy", 32'(recv_rdy), 32'd0);
    check("async_count", 32'(count), 32'd0);
    model_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    cycle(1'b1, 32'hDEAD_BEEF, 1'b0);
    check("post_rst_head", send_msg, 32'hDEAD_BEEF);
    check("post_rst_count", 32'(count), 32'd1);
    drain_all();

    // Empty FIFO, push and pop requested together.
    recv_val = 1'b1;
    recv_msg = 32'h1234_5678;
    send_rdy = 1'b1;
    #2;
`ifdef STREAM_FIFO_BYPASS_EN
    check("byp_send_val", 32'(send_val), 32'd1);
    check("byp_send_msg", send_msg, 32'h1234_5678);
`else
    check("nobyp_send_val", 32'(send_val), 32'd0);
`endif
    cycle(1'b1, 32'h1234_5678, 1'b1);
`ifdef STREAM_FIFO_BYPASS_EN
    check("byp_count", 32'(count), 32'd0);
`else
    check("nobyp_count", 32'(count), 32'd1);
`endif
    drain_all();

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    end
    drain_all();
    check("final_count", 32'(count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_stream_fifo
